pes_seq_comparator: RTL and testbench
=====================================

// Module: pes_seq_comparator
// PURPOSE
//  Multi-cycle magnitude comparator controller for WIDTH-bit unsigned operands.
//  Scans operands MSB-first, one 2-bit slice per cycle, through a single shared
//  2-bit slice comparator. Start/done handshake; sits beside datapath blocks
//  that need a cheap A<B / A==B / A>B decision.
//  Optional early exit once a slice differs.
// PARAMETERS
//  WIDTH       8  operand width; must be even and >= 2; NS = WIDTH/2 slices
//  EARLY_EXIT  1  1: finish on first unequal slice; 0: always scan all NS slices
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request; accepted only when state is IDLE or DONE
//  a            in   WIDTH  operand A; sampled on accepting edge only
//  b            in   WIDTH  operand B; sampled on accepting edge only
//  busy         out  1      high while in SCAN
//  done         out  1      one-cycle pulse; result flags are valid in that cycle
//  a_less_b     out  1      result; held from done until next accepted start
//  a_equal_b    out  1      result; held as above
//  a_greater_b  out  1      result; held as above
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, busy=0, done=0, all three flags=0,
//   slice index=0, operand regs=0. Reset mid-SCAN aborts with no done pulse.
//  States: IDLE -> SCAN on start; SCAN -> SCAN while undecided and idx>0;
//   SCAN -> DONE when decided (EARLY_EXIT=1) or last slice (idx==0) evaluated;
//   DONE -> SCAN if start, else IDLE. DONE lasts exactly one cycle.
//  Accept edge: capture a,b; idx=NS-1; clear decision reg to EQ; clear flags.
//  SCAN cycle: compare slice a_r[2*idx+1:2*idx] vs b_r[...] combinationally.
//   - Decision is still EQ and slice unequal: decision = slice LT/GT; it is final.
//   - A decision already made is never overwritten by later slices (EARLY_EXIT=0).
//   - Decrement idx each SCAN cycle; it must not wrap below 0.
//  Entering DONE: flags register the decision, exactly one flag high (one-hot).
//  Latency, start accepted at edge k, m = slices examined:
//   busy high in cycles k+1..k+m; done high in cycle k+m+1.
//   EARLY_EXIT=0: m=NS always. EARLY_EXIT=1: m = 1 + index distance from MSB
//   slice to first unequal slice, or NS if equal.
//  start while busy: ignored; no effect on operands, idx or result.
//  start during DONE cycle: accepted, back-to-back. done still pulses this cycle;
//   flags are cleared at that edge.
//  Inputs a,b may change freely except on the accepting edge.
//  Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Package pes_cmp_pkg:
//   - state enum {IDLE, SCAN, DONE}
//   - 2-bit result code: EQ=2'b00, LT=2'b01, GT=2'b10
//   - function slice_count(WIDTH)
//  Sub-module pes_cmp2_slice: purely combinational 2-bit compare, outputs lt/eq/gt.
//   Instantiated once and shared across all slices.
//  Top: FSM, operand regs, idx counter ($clog2(NS), min 1 bit), decision reg,
//   output regs. Elaboration check: WIDTH even and >= 2.
// TESTING (WIDTH=8 unless noted)
//  1 a=8'hA5,b=8'hA5, start@k -> busy k+1..k+4, done@k+5, eq=1 lt=0 gt=0.
//  2 a=8'h80,b=8'h7F, EARLY_EXIT=1 -> done@k+2, gt=1.
//    Same stimulus with EARLY_EXIT=0 -> done@k+5, gt=1.
//  3 a=8'h12,b=8'h13 -> done@k+5, lt=1; flags held until next start.
//    Then a second start in the done cycle with a=8'hFF,b=8'h00 -> gt=1, done@+2.
//  4 start pulses and changed a,b during busy -> ignored; result reflects
//    originally captured operands; exactly one done pulse.
//  5 rst asserted asynchronously at k+2 mid-SCAN -> all outputs 0 immediately,
//    no done; a fresh start after release completes normally.
//  6 Random sweep, WIDTH=2 and WIDTH=16, both EARLY_EXIT values, vs reference
//    model: flags one-hot at done; latency matches formula.

Source files
------------

// File: rtl/pes_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pes_cmp_pkg
// Purpose  : Shared types and helpers for the sequential magnitude comparator.
//            state_t  - controller states (IDLE / SCAN / DONE)
//            result_t - 2-bit running decision code (EQ / LT / GT)
//            slice_count() - number of 2-bit slices in a WIDTH-bit operand
// Revision : 1.0 - initial release
// ============================================================================
package pes_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        LT = 2'b01,
        GT = 2'b10
    } result_t;

    function automatic int slice_count(input int width);
        return width / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pes_seq_comparator_if.sv
`default_nettype none
// ============================================================================
// Module   : pes_seq_comparator_if
// Purpose  : Start/done handshake and operand/result bundle for the
//            sequential comparator.
//            master : drives start, a, b; observes busy, done, result flags
//            slave  : the comparator side
// Revision : 1.0 - initial release
// ============================================================================
interface pes_seq_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_less_b;
    logic             a_equal_b;
    logic             a_greater_b;

    modport master (
        output start, a, b,
        input  busy, done, a_less_b, a_equal_b, a_greater_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_less_b, a_equal_b, a_greater_b
    );
endinterface
`default_nettype wire

// File: rtl/pes_cmp2_slice.sv
`default_nettype none
// ============================================================================
// Module   : pes_cmp2_slice
// Purpose  : Purely combinational unsigned compare of two 2-bit slices.
// Ports    : i_a, i_b        2-bit slices
//            o_lt/o_eq/o_gt  one-hot relation of i_a to i_b
// Revision : 1.0 - initial release
// ============================================================================
module pes_cmp2_slice (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_lt,
    output logic       o_eq,
    output logic       o_gt
);
    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
endmodule
`default_nettype wire

// File: rtl/pes_seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : pes_seq_comparator
// Purpose  : Multi-cycle WIDTH-bit unsigned magnitude comparator. Scans the
//            captured operands MSB-first, one 2-bit slice per cycle, through a
//            single shared slice comparator, then pulses done with one-hot
//            A<B / A==B / A>B flags that are held until the next start.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - slave side of pes_seq_comparator_if
//                   (start, a, b in; busy, done, a_less_b, a_equal_b,
//                    a_greater_b out)
// Params   : WIDTH      - operand width, even and >= 2
//            EARLY_EXIT - 1: stop on first unequal slice; 0: scan all slices
// Revision : 1.0 - initial release
// ============================================================================
module pes_seq_comparator
    import pes_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    pes_seq_comparator_if.slave bus
);

    localparam int              NS        = slice_count(WIDTH);
    localparam int              IDXW      = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDXW-1:0] C_IDX_TOP = IDXW'(NS - 1);

    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_check
            $error("pes_seq_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    result_t          r_dec;
    result_t          w_dec_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [1:0]       w_sa;
    logic [1:0]       w_sb;
    logic             w_slice_lt;
    logic             w_slice_eq;
    logic             w_slice_gt;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;

    // Slice idx occupies bits [2*idx+1 : 2*idx].
    assign w_sa = r_a[{r_idx, 1'b0} +: 2];
    assign w_sb = r_b[{r_idx, 1'b0} +: 2];

    pes_cmp2_slice u_slice (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .o_lt (w_slice_lt),
        .o_eq (w_slice_eq),
        .o_gt (w_slice_gt)
    );

    // Start is honoured only when no scan is in flight.
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    // The first unequal slice (MSB-first) settles the answer; later slices
    // can never override it.
    always_comb begin
        w_dec_nxt = r_dec;
        if ((r_dec == EQ) && !w_slice_eq) begin
            if (w_slice_lt) begin
                w_dec_nxt = LT;
            end else if (w_slice_gt) begin
                w_dec_nxt = GT;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if ((EARLY_EXIT && (w_dec_nxt != EQ)) || (r_idx == '0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = bus.start ? SCAN : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode (from the state register only)
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            SCAN:    w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, slice index, running decision and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_dec <= EQ;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_idx <= C_IDX_TOP;
            r_dec <= EQ;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (r_state == SCAN) begin
            r_dec <= w_dec_nxt;
            // Saturate at slice 0 so the index never wraps.
            if (r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_state_nxt == DONE) begin
                r_lt <= (w_dec_nxt == LT);
                r_eq <= (w_dec_nxt == EQ);
                r_gt <= (w_dec_nxt == GT);
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.a_less_b    = r_lt;
    assign bus.a_equal_b   = r_eq;
    assign bus.a_greater_b = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_pes_seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pes_seq_comparator
// Purpose  : Self-checking bench for pes_seq_comparator. Six instances
//            (WIDTH 8/16/2 x EARLY_EXIT 1/0) share start and the low bits of
//            one 16-bit operand pair; each is checked every cycle against
//            the expected busy/done/flag sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pes_seq_comparator;

    localparam int NDUT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    pes_seq_comparator_if #(.WIDTH(8))  if_w8_e1  ();
    pes_seq_comparator_if #(.WIDTH(8))  if_w8_e0  ();
    pes_seq_comparator_if #(.WIDTH(16)) if_w16_e1 ();
    pes_seq_comparator_if #(.WIDTH(16)) if_w16_e0 ();
    pes_seq_comparator_if #(.WIDTH(2))  if_w2_e1  ();
    pes_seq_comparator_if #(.WIDTH(2))  if_w2_e0  ();

    assign if_w8_e1.start  = start; assign if_w8_e1.a  = op_a[7:0]; assign if_w8_e1.b  = op_b[7:0];
    assign if_w8_e0.start  = start; assign if_w8_e0.a  = op_a[7:0]; assign if_w8_e0.b  = op_b[7:0];
    assign if_w16_e1.start = start; assign if_w16_e1.a = op_a;      assign if_w16_e1.b = op_b;
    assign if_w16_e0.start = start; assign if_w16_e0.a = op_a;      assign if_w16_e0.b = op_b;
    assign if_w2_e1.start  = start; assign if_w2_e1.a  = op_a[1:0]; assign if_w2_e1.b  = op_b[1:0];
    assign if_w2_e0.start  = start; assign if_w2_e0.a  = op_a[1:0]; assign if_w2_e0.b  = op_b[1:0];

    pes_seq_comparator #(.WIDTH(8),  .EARLY_EXIT(1'b1)) u_w8_e1  (.clk(clk), .rst(rst), .bus(if_w8_e1));
    pes_seq_comparator #(.WIDTH(8),  .EARLY_EXIT(1'b0)) u_w8_e0  (.clk(clk), .rst(rst), .bus(if_w8_e0));
    pes_seq_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_w16_e1 (.clk(clk), .rst(rst), .bus(if_w16_e1));
    pes_seq_comparator #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_w16_e0 (.clk(clk), .rst(rst), .bus(if_w16_e0));
    pes_seq_comparator #(.WIDTH(2),  .EARLY_EXIT(1'b1)) u_w2_e1  (.clk(clk), .rst(rst), .bus(if_w2_e1));
    pes_seq_comparator #(.WIDTH(2),  .EARLY_EXIT(1'b0)) u_w2_e0  (.clk(clk), .rst(rst), .bus(if_w2_e0));

    // Observation word per instance: {busy, done, lt, eq, gt}
    wire [NDUT-1:0][4:0] obs;
    assign obs[0] = {if_w8_e1.busy,  if_w8_e1.done,  if_w8_e1.a_less_b,  if_w8_e1.a_equal_b,  if_w8_e1.a_greater_b};
    assign obs[1] = {if_w8_e0.busy,  if_w8_e0.done,  if_w8_e0.a_less_b,  if_w8_e0.a_equal_b,  if_w8_e0.a_greater_b};
    assign obs[2] = {if_w16_e1.busy, if_w16_e1.done, if_w16_e1.a_less_b, if_w16_e1.a_equal_b, if_w16_e1.a_greater_b};
    assign obs[3] = {if_w16_e0.busy, if_w16_e0.done, if_w16_e0.a_less_b, if_w16_e0.a_equal_b, if_w16_e0.a_greater_b};
    assign obs[4] = {if_w2_e1.busy,  if_w2_e1.done,  if_w2_e1.a_less_b,  if_w2_e1.a_equal_b,  if_w2_e1.a_greater_b};
    assign obs[5] = {if_w2_e0.busy,  if_w2_e0.done,  if_w2_e0.a_less_b,  if_w2_e0.a_equal_b,  if_w2_e0.a_greater_b};

    function automatic int width_of(input int d);
        return (d < 2) ? 8 : (d < 4) ? 16 : 2;
    endfunction

    function automatic bit ee_of(input int d);
        return (d % 2) == 0;
    endfunction

    // Slices examined: all of them without early exit, else up to and
    // including the slice holding the most significant differing bit.
    function automatic int exp_m(input logic [15:0] a, input logic [15:0] b,
                                 input int w, input bit ee);
        int ns;
        ns = w / 2;
        if (!ee) return ns;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return ns - (i / 2);
        end
        return ns;
    endfunction

    // Expected {lt, eq, gt} of the low w bits.
    function automatic logic [2:0] exp_f(input logic [15:0] a, input logic [15:0] b,
                                         input int w);
        logic [15:0] msk;
        logic [15:0] ma;
        logic [15:0] mb;
        msk = (w >= 16) ? 16'hFFFF : 16'((32'h1 << w) - 32'h1);
        ma  = a & msk;
        mb  = b & msk;
        if (ma < mb)  return 3'b100;
        if (ma == mb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input int d, input logic [4:0] o,
                         input logic [4:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed={busy,done,lt,eq,gt}=%b expected=%b",
                   tag, d, o, e);
        end
    endtask

    // Launch one transaction and check instances in mask for cycles
    // k+1 .. k+stop. disturb: pulse start with different operands while busy.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [NDUT-1:0] mask, input int stop, input bit disturb);
        int         m [NDUT];
        logic [2:0] f [NDUT];
        logic [4:0] e;
        for (int d = 0; d < NDUT; d++) begin
            m[d] = exp_m(a, b, width_of(d), ee_of(d));
            f[d] = exp_f(a, b, width_of(d));
        end
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= stop; j++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (mask[d]) begin
                    e = {(j <= m[d]), (j == m[d] + 1), (j > m[d]) ? f[d] : 3'b000};
                    check(tag, d, obs[d], e);
                end
            end
            if (j < stop) begin
                if (disturb && (j <= 3)) begin
                    @(negedge clk);
                    op_a  = ~a;
                    op_b  = 16'h0000;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic settle(input int n);
        start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 16'h0000;
        op_b  = 16'h0000;

        // Reset state
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) check("reset", d, obs[d], 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        // Equal operands: full scan everywhere
        run("eq_a5", 16'h00A5, 16'h00A5, 6'h3F, 10, 1'b0);
        // MSB slice differs: early exit after one slice
        run("gt_msb", 16'h0080, 16'h007F, 6'h3F, 10, 1'b0);

        // LSB slice decides, then a back-to-back start in the done cycle
        run("lt_lsb", 16'h0012, 16'h0013, 6'h03, 5, 1'b0);
        run("b2b_gt", 16'h00FF, 16'h0000, 6'h03, 6, 1'b0);
        settle(12);

        // start and operand changes while busy are ignored
        run("busy_ign", 16'h003C, 16'h003D, 6'h03, 10, 1'b1);
        settle(12);

        // Asynchronous reset mid-scan
        run("pre_rst", 16'h0012, 16'h0013, 6'h3F, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) check("rst_async", d, obs[d], 5'b00000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) check("no_done", d, obs[d], 5'b00000);
        end
        run("after_rst", 16'h00C3, 16'h00C1, 6'h3F, 10, 1'b0);

        // Mixed sweep: equal, single-bit difference, unrelated operands
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            case (i % 3)
                0:       rb = ra;
                1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run("sweep", ra, rb, 6'h3F, 10, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
